div_hilo_controller: RTL and testbench
======================================

Name: div_hilo_controller

Overview:
- Sequences the multi-cycle signed DIV for the pipelined core and owns the architectural HI/LO registers.
- Accepts a divide issued from the execute stage and runs a radix-2 restoring divide over WIDTH iterations.
- Writes quotient to LO and remainder to HI, and generates the decode-stage stall that holds MFHI/MFLO/DIV until results are ready.
- Sits beside the ALU in execute; HI/LO outputs feed the writeback mux selected by is_mf_hi/is_mf_lo.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 2.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous active-high reset
- StartDivE  input  1  execute stage holds a valid DIV this cycle (HasDivD piped to E, already qualified by flush)
- SrcAE  input  WIDTH  dividend (rs)
- SrcBE  input  WIDTH  divisor (rt)
- HasDivD  input  1  decode stage holds a DIV
- is_mf_hiD  input  1  decode stage holds MFHI
- is_mf_loD  input  1  decode stage holds MFLO
- StallDivD  output  1  stall F/D, bubble E
- BusyDiv  output  1  divide in progress (state != IDLE)
- HiOut  output  WIDTH  HI register
- LoOut  output  WIDTH  LO register

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-high.
- Reset values:
  - state=IDLE; HI=0, LO=0; BusyDiv=0.
  - StallDivD=0 unless StartDivE and a decode hazard are high; it is combinational.
  - Internal counter, remainder and quotient shift registers = 0.
- States: IDLE, BUSY, FIX.
- IDLE:
  - StartDivE=1 at edge N: latch |SrcAE| into quotient shift register and |SrcBE| into divisor register.
  - Record negQ = signA XOR signB and negR = signA; clear partial remainder; count=WIDTH.
  - If SrcBE==0, go to FIX with the zero-divide flag set; otherwise go to BUSY.
  - StartDivE=0: stay in IDLE.
- BUSY:
  - Each edge performs one restoring step: shift {rem,quo} left 1; trial = rem - divisor.
  - If trial is non-negative: rem=trial, quo[0]=1; else quo[0]=0.
  - count decrements; when count reaches 0 (after WIDTH steps), go to FIX.
- FIX (one cycle), at the edge leaving FIX:
  - LO = negQ ? -quo : quo.
  - HI = negR ? -rem : rem.
  - Then go to IDLE.
  - Zero-divide: LO = {WIDTH{1'b1}}, HI = SrcAE as latched (raw dividend), with no sign fix.
- Latency:
  - Normal divide: HI/LO update at edge N+WIDTH+1, so N+33 for WIDTH=32.
  - Zero divide: HI/LO update at edge N+2.
  - BusyDiv is high from after edge N until after the HI/LO update edge.
- Arithmetic:
  - Absolute value uses two's-complement negate; the most negative value maps to itself, interpreted as unsigned.
  - Most negative / -1: LO = 0x80000000, HI = 0 (wraps, no trap).
  - The trial subtract is WIDTH+1 bits wide to keep the borrow.
- Stall: StallDivD = (is_mf_hiD | is_mf_loD | HasDivD) & (BusyDiv | StartDivE).
  - StartDivE is included so a dependent instruction directly behind a DIV is caught.
  - StallDivD drops in the cycle after the HI/LO update edge; the stalled MFHI/MFLO then reads the new value.
- StartDivE while not IDLE: ignored, and the current operation is unaffected. The stall makes this unreachable in a legal pipeline; the verifier still checks the ignore behaviour.
- HI/LO hold their values in every state except at the FIX exit edge.
- Reset asserted mid-operation: immediate return to IDLE, HI/LO cleared, no partial write.

Optional Feature:
- Macro: DIV_UNSIGNED_EN.
- Defined:
  - Adds input port IsUnsignedE (1 bit), sampled with StartDivE.
  - When IsUnsignedE=1: no absolute value, negQ=negR=0, operands treated as unsigned (DIVU).
  - DIVU zero-divide gives LO=all ones, HI=dividend.
- Not defined:
  - Port absent; all divides are signed.

Test Plan:
- 100 / 7: StartDivE at edge N -> BusyDiv high; at edge N+33 LO=14, HI=2; BusyDiv low after.
- -100 / 7: LO=0xFFFFFFF2 (-14), HI=0xFFFFFFFE (-2). Also check 100 / -7 gives LO=-14, HI=2.
- 7 / 0: LO=0xFFFFFFFF, HI=7 at edge N+2; BusyDiv high for exactly 2 cycles.
- 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MFHI in decode one cycle after DIV enters E:
  - StallDivD=1 from the StartDivE cycle until the HI update edge.
  - StallDivD=0 the next cycle, with HiOut=result.
  - A second StartDivE pulsed mid-BUSY does not alter the result.
- Reset pulsed asynchronously at step 10 of a divide: state IDLE, HI=LO=0, BusyDiv=0 immediately. A new 9/3 divide then yields LO=3, HI=0.

Source files
------------

// File: rtl/div_hilo_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : div_hilo_controller_if
// Description : Execute/decode-side signal bundle for the DIV sequencer and
//               HI/LO register file. IsUnsignedE exists only with
//               DIV_UNSIGNED_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_hilo_controller_if #(
    parameter int WIDTH = 32
);
    logic             StartDivE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic             HasDivD;
    logic             is_mf_hiD;
    logic             is_mf_loD;
`ifdef DIV_UNSIGNED_EN
    logic             IsUnsignedE;
`endif
    logic             StallDivD;
    logic             BusyDiv;
    logic [WIDTH-1:0] HiOut;
    logic [WIDTH-1:0] LoOut;

    // Pipeline side: issues divides, observes stall and HI/LO
    modport master (
`ifdef DIV_UNSIGNED_EN
        output IsUnsignedE,
`endif
        output StartDivE, SrcAE, SrcBE, HasDivD, is_mf_hiD, is_mf_loD,
        input  StallDivD, BusyDiv, HiOut, LoOut
    );

    modport slave (
`ifdef DIV_UNSIGNED_EN
        input  IsUnsignedE,
`endif
        input  StartDivE, SrcAE, SrcBE, HasDivD, is_mf_hiD, is_mf_loD,
        output StallDivD, BusyDiv, HiOut, LoOut
    );
endinterface
`default_nettype wire

// File: rtl/div_hilo_controller.sv
`default_nettype none
// ============================================================================
// Module      : div_hilo_controller
// Description : Multi-cycle radix-2 restoring signed divider owning HI/LO,
//               with decode-stage stall generation. Define DIV_UNSIGNED_EN
//               to add DIVU support via IsUnsignedE.
// Revision    : 1.0 - initial release
// ============================================================================
module div_hilo_controller #(
    parameter int WIDTH = 32
) (
    input wire logic              clock,
    input wire logic              reset,
    div_hilo_controller_if.slave  bus
);
    localparam int c_CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic [WIDTH-1:0]   r_dividend;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_zero;
    logic               r_busy;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_unsigned;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_div_zero;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;

`ifdef DIV_UNSIGNED_EN
    assign w_unsigned = bus.IsUnsignedE;
`else
    assign w_unsigned = 1'b0;
`endif

    // Most negative value negates to itself and is then read as unsigned
    assign w_sign_a   = bus.SrcAE[WIDTH-1] & ~w_unsigned;
    assign w_sign_b   = bus.SrcBE[WIDTH-1] & ~w_unsigned;
    assign w_abs_a    = w_sign_a ? -bus.SrcAE : bus.SrcAE;
    assign w_abs_b    = w_sign_b ? -bus.SrcBE : bus.SrcBE;
    assign w_div_zero = (bus.SrcBE == '0);

    // Top bit of the WIDTH+1 bit difference is the borrow
    assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
    assign w_trial    = w_rem_sh - {1'b0, r_div};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_div      <= '0;
            r_dividend <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_zero     <= 1'b0;
            r_busy     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.StartDivE) begin
                        r_quo      <= w_abs_a;
                        r_div      <= w_abs_b;
                        r_dividend <= bus.SrcAE;
                        r_neg_q    <= w_sign_a ^ w_sign_b;
                        r_neg_r    <= w_sign_a;
                        r_rem      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_FIX;
                        // Zero divide holds one extra cycle in FIX so HI/LO
                        // land two edges after issue
                        if (w_div_zero) begin
                            r_zero  <= 1'b1;
                            r_count <= c_CNT_W'(1);
                        end else begin
                            r_zero  <= 1'b0;
                            r_count <= c_CNT_W'(WIDTH);
                            r_state <= S_BUSY;
                        end
                    end
                end

                S_BUSY: begin
                    if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_rem_sh[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                    r_count <= r_count - c_CNT_W'(1);
                    if (r_count == c_CNT_W'(1)) begin
                        r_state <= S_FIX;
                    end
                end

                S_FIX: begin
                    if (r_count != '0) begin
                        r_count <= r_count - c_CNT_W'(1);
                    end else begin
                        if (r_zero) begin
                            r_lo <= '1;
                            r_hi <= r_dividend;
                        end else begin
                            r_lo <= r_neg_q ? -r_quo : r_quo;
                            r_hi <= r_neg_r ? -r_rem : r_rem;
                        end
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // StartDivE term catches a dependent instruction directly behind the DIV
    assign bus.StallDivD = (bus.is_mf_hiD | bus.is_mf_loD | bus.HasDivD) &
                           (r_busy | bus.StartDivE);
    assign bus.BusyDiv   = r_busy;
    assign bus.HiOut     = r_hi;
    assign bus.LoOut     = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_div_hilo_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_hilo_controller
// Description : Directed scoreboard bench for div_hilo_controller (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_hilo_controller;
    localparam int WIDTH = 32;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   cyc;
    int   start_cyc;
    logic prev_busy;
    exp_t sb_q[$];

    div_hilo_controller_if #(.WIDTH(WIDTH)) dut_if ();

    div_hilo_controller #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (dut_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: records issue edge, pops scoreboard when BusyDiv falls
    always @(negedge clock) begin
        if (reset) begin
            prev_busy = 1'b0;
        end else begin
            if (!dut_if.BusyDiv && dut_if.StartDivE) begin
                start_cyc = cyc + 1;
            end
            if (prev_busy && !dut_if.BusyDiv) begin
                if (sb_q.size() == 0) begin
                    n_checks = n_checks + 1;
                    n_errors = n_errors + 1;
                    $display("FAIL unexpected_result: got hi=%h lo=%h expected none",
                             dut_if.HiOut, dut_if.LoOut);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("lo", dut_if.LoOut, e.lo);
                    check("hi", dut_if.HiOut, e.hi);
                    check("latency", 32'(cyc - start_cyc), 32'(e.lat));
                end
            end
            prev_busy = dut_if.BusyDiv;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (dut_if.BusyDiv && n < 60) begin
            @(negedge clock);
            n = n + 1;
        end
        check("idle_timeout_busy", {31'b0, dut_if.BusyDiv}, 32'd0);
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] hi, input logic [31:0] lo,
                           input int lat, input logic hz_div, input logic hz_lo);
        exp_t e;
        e.hi = hi;
        e.lo = lo;
        e.lat = lat;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        dut_if.StartDivE = 1'b1;
        dut_if.SrcAE     = a;
        dut_if.SrcBE     = b;
        dut_if.HasDivD   = hz_div;
        dut_if.is_mf_loD = hz_lo;
        @(negedge clock);
        check("stall_issue", {31'b0, dut_if.StallDivD}, {31'b0, hz_div | hz_lo});
        @(posedge clock);
        #1;
        dut_if.StartDivE = 1'b0;
        dut_if.HasDivD   = 1'b0;
        dut_if.is_mf_loD = 1'b0;
        check("busy_rise", {31'b0, dut_if.BusyDiv}, 32'd1);
        wait_idle();
        @(negedge clock);
    endtask

    initial begin
        exp_t e;
        int   i;
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        start_cyc = 0;
        prev_busy = 1'b0;
        reset     = 1'b1;
        dut_if.StartDivE = 1'b0;
        dut_if.SrcAE     = '0;
        dut_if.SrcBE     = '0;
        dut_if.HasDivD   = 1'b0;
        dut_if.is_mf_hiD = 1'b0;
        dut_if.is_mf_loD = 1'b0;
`ifdef DIV_UNSIGNED_EN
        dut_if.IsUnsignedE = 1'b0;
`endif
        #12;
        check("rst_hi", dut_if.HiOut, 32'd0);
        check("rst_lo", dut_if.LoOut, 32'd0);
        check("rst_busy", {31'b0, dut_if.BusyDiv}, 32'd0);
        check("rst_stall", {31'b0, dut_if.StallDivD}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // 100/7 with MFHI in decode, plus a stray StartDivE mid-BUSY
        e.hi = 32'd2; e.lo = 32'd14; e.lat = 33;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        dut_if.StartDivE = 1'b1;
        dut_if.SrcAE     = 32'd100;
        dut_if.SrcBE     = 32'd7;
        dut_if.is_mf_hiD = 1'b1;
        @(negedge clock);
        check("stall_start", {31'b0, dut_if.StallDivD}, 32'd1);
        @(posedge clock);
        #1;
        dut_if.StartDivE = 1'b0;
        check("busy_rise", {31'b0, dut_if.BusyDiv}, 32'd1);
        for (i = 0; i < 60; i++) begin
            @(negedge clock);
            if (i == 11) begin
                dut_if.StartDivE = 1'b0;
            end
            if (!dut_if.BusyDiv) break;
            check("stall_busy", {31'b0, dut_if.StallDivD}, 32'd1);
            if (i == 10) begin
                dut_if.StartDivE = 1'b1;
                dut_if.SrcAE     = 32'd50;
                dut_if.SrcBE     = 32'd5;
            end
        end
        check("stall_release", {31'b0, dut_if.StallDivD}, 32'd0);
        check("mfhi_value", dut_if.HiOut, 32'd2);
        dut_if.is_mf_hiD = 1'b0;
        @(negedge clock);

        run_div(32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2, 33, 1'b0, 1'b0);
        run_div(32'd100,       32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2, 33, 1'b1, 1'b0);
        run_div(32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 2,  1'b0, 1'b1);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33, 1'b0, 1'b0);
        run_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14,        33, 1'b0, 1'b0);

        // Asynchronous reset at step 10 of a divide: no result expected
        @(posedge clock);
        #1;
        dut_if.StartDivE = 1'b1;
        dut_if.SrcAE     = 32'd1000;
        dut_if.SrcBE     = 32'd3;
        @(posedge clock);
        #1;
        dut_if.StartDivE = 1'b0;
        repeat (9) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", {31'b0, dut_if.BusyDiv}, 32'd0);
        check("arst_hi", dut_if.HiOut, 32'd0);
        check("arst_lo", dut_if.LoOut, 32'd0);
        #5;
        reset = 1'b0;

        run_div(32'd9, 32'd3, 32'd0, 32'd3, 33, 1'b0, 1'b0);

        repeat (3) @(negedge clock);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
